// File: rtl/fifo_byte_drain.sv
// rtl/fifo_byte_drain.sv - drains a burst of FIFO words into an MSB-first byte stream with an order check
module fifo_byte_drain #(
    parameter int W         = 16,
    parameter int BURST_LEN = 256,
    parameter int CNT_W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         r_trigger,
    input  logic [W-1:0] r_data,
    input  logic         r_ready,
    output logic [7:0]   o_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_last,
    output logic         done,
    output logic         seq_err
);

    localparam int NB   = W / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [BI_W-1:0]  byte_idx_q, byte_idx_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     last_word_q, last_word_d;
    logic             have_last_q, have_last_d;
    logic             seq_err_q, seq_err_d;
    logic             busy_q, busy_d;
    logic             r_trigger_q, r_trigger_d;
    logic [7:0]       o_data_q, o_data_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic             done_q, done_d;

    logic             word_last;
    logic [BI_W-1:0]  next_idx;

    // Byte idx of a word counted from the MSB end.
    function automatic logic [7:0] pick_byte(input logic [W-1:0] w, input logic [BI_W-1:0] idx);
        return 8'(w >> (8 * (NB - 1 - int'(idx))));
    endfunction

    assign word_last = (word_cnt_q == LAST_WORD);
    assign next_idx  = byte_idx_q + BI_W'(1);

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        last_word_d = last_word_q;
        have_last_d = have_last_q;
        seq_err_d   = seq_err_q;
        busy_d      = busy_q;
        r_trigger_d = r_trigger_q;
        o_data_d    = o_data_q;
        o_valid_d   = o_valid_q;
        o_last_d    = o_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    word_cnt_d  = '0;
                    busy_d      = 1'b1;
                    r_trigger_d = 1'b1;
                end
            end
            FETCH: begin
                if (r_ready && r_trigger_q) begin
                    if (have_last_q && (r_data < last_word_q)) begin
                        seq_err_d = 1'b1;
                    end
                    last_word_d = r_data;
                    have_last_d = 1'b1;
                    shift_d     = r_data;
                    byte_idx_d  = '0;
                    r_trigger_d = 1'b0;
                    o_valid_d   = 1'b1;
                    o_data_d    = pick_byte(r_data, '0);
                    o_last_d    = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (o_valid_q && o_ready) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = next_idx;
                        o_data_d   = pick_byte(shift_q, next_idx);
                        o_last_d   = word_last && (next_idx == LAST_BYTE);
                    end else begin
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                        if (word_last) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            word_cnt_d  = word_cnt_q + CNT_W'(1);
                            r_trigger_d = 1'b1;
                            state_d     = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            last_word_q <= '0;
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            r_trigger_q <= 1'b0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            last_word_q <= last_word_d;
            have_last_q <= have_last_d;
            seq_err_q   <= seq_err_d;
            busy_q      <= busy_d;
            r_trigger_q <= r_trigger_d;
            o_data_q    <= o_data_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign r_trigger = r_trigger_q;
    assign o_data    = o_data_q;
    assign o_valid   = o_valid_q;
    assign o_last    = o_last_q;
    assign done      = done_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fifo_byte_drain.sv
// tb/tb_fifo_byte_drain.sv - directed self-checking bench for fifo_byte_drain
module tb_fifo_byte_drain;

    localparam int W  = 16;
    localparam int BL = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         r_ready = 1'b0;
    logic         o_ready = 1'b0;
    logic [W-1:0] r_data;
    logic         busy, r_trigger, o_valid, o_last, done, seq_err;
    logic [7:0]   o_data;

    logic [W-1:0] words [0:4095];
    int           rd_ptr = 0;
    logic [8:0]   cap [0:8191];
    int           cap_n = 0;
    int           done_cnt = 0;
    int           total = 0;
    int           bad = 0;

    fifo_byte_drain #(.W(W), .BURST_LEN(BL), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .r_trigger(r_trigger), .r_data(r_data), .r_ready(r_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
        .done(done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // FIFO model: the word at rd_ptr is presented, and popped on a read handshake.
    assign r_data = words[rd_ptr];
    always @(posedge clk) if (r_ready && r_trigger) rd_ptr <= rd_ptr + 1;

    // Byte sink / done monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (o_valid && o_ready) begin
            cap[cap_n] <= {o_last, o_data};
            cap_n      <= cap_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic fill(input int n, input logic [W-1:0] base, input logic [W-1:0] step);
        for (int k = 0; k < n; k++) words[rd_ptr + k] = base + W'(k) * step;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cyc);
        cyc = 2;
        while (!done && cyc < bound) begin
            tick;
            cyc++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic verify_burst(input string tag, input int cb, input int wb);
        int           errs;
        logic [W-1:0] w;
        logic [8:0]   exp;
        errs = 0;
        for (int i = 0; i < 2 * BL; i++) begin
            w   = words[wb + i / 2];
            exp = {(i == 2 * BL - 1), ((i % 2) == 0) ? w[15:8] : w[7:0]};
            if (cap[cb + i] !== exp) errs++;
        end
        check({tag, "_nbytes"}, 32'(cap_n - cb), 32'(2 * BL));
        check({tag, "_bytes"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int cyc, cb, wb, dc0, errs, ph, hold_err, trig_err, stall_ab, xk;
        logic prev_stall, pend;
        logic [7:0] prev;

        // Reset state
        #2;
        check("rst_outs", 32'({busy, r_trigger, o_valid, o_last, done, seq_err, o_data}), 32'd0);
        do_reset;
        check("idle_outs", 32'({busy, r_trigger, o_valid, o_last, done, seq_err, o_data}), 32'd0);

        // Basic burst 0x0000..0x00FF
        fill(BL, 16'h0000, 16'h0001);
        wb = rd_ptr; cb = cap_n;
        r_ready = 1'b1; o_ready = 1'b1;
        pulse_start;
        check("t1_busy", 32'({busy, r_trigger}), 32'b11);
        wait_done("t1", 2000, cyc);
        check("t1_latency", 32'(cyc), 32'd770);
        verify_burst("t1", cb, wb);
        check("t1_byte3", 32'(cap[cb + 3]), 32'h001);
        check("t1_byte510", 32'(cap[cb + 510]), 32'h000);
        check("t1_last", 32'(cap[cb + 511]), 32'h1FF);
        check("t1_seq", 32'(seq_err), 32'd0);
        tick;
        check("t1_idle", 32'({busy, done}), 32'd0);

        // Backpressure on repeated 0xABCD (equal words are not an error)
        fill(BL, 16'hABCD, 16'h0000);
        wb = rd_ptr; cb = cap_n;
        pulse_start;
        ph = 0; hold_err = 0; trig_err = 0; stall_ab = 0; prev_stall = 1'b0; prev = 8'h00; cyc = 0;
        while (!done && cyc < 6000) begin
            o_ready = (ph == 0);
            ph = (ph + 1) % 3;
            if (prev_stall && o_data !== prev) hold_err++;
            if (o_valid && r_trigger) trig_err++;
            if (o_valid && !o_ready && o_data == 8'hAB) stall_ab++;
            prev_stall = o_valid && !o_ready;
            prev = o_data;
            tick;
            cyc++;
        end
        o_ready = 1'b1;
        check("t2_done", 32'(done), 32'd1);
        check("t2_hold", 32'(hold_err), 32'd0);
        check("t2_trig_in_shift", 32'(trig_err), 32'd0);
        check("t2_stall_ab_seen", 32'(stall_ab > 0), 32'd1);
        check("t2_b0", 32'(cap[cb]), 32'h0AB);
        check("t2_b1", 32'(cap[cb + 1]), 32'h0CD);
        verify_burst("t2", cb, wb);
        check("t2_seq_equal", 32'(seq_err), 32'd0);
        tick;

        // Empty FIFO for 50 cycles
        fill(BL, 16'hB000, 16'h0001);
        wb = rd_ptr; cb = cap_n;
        r_ready = 1'b0;
        pulse_start;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            if (!r_trigger || o_valid) errs++;
            tick;
        end
        check("t3_wait", 32'(errs), 32'd0);
        check("t3_nothing", 32'(cap_n - cb), 32'd0);
        r_ready = 1'b1;
        wait_done("t3", 2000, cyc);
        verify_burst("t3", cb, wb);
        tick;

        // Sequence error: 5, 5, 4, ...
        do_reset;
        fill(BL, 16'h0004, 16'h0000);
        words[rd_ptr] = 16'h0005;
        words[rd_ptr + 1] = 16'h0005;
        wb = rd_ptr; cb = cap_n;
        pulse_start;
        xk = 0; pend = 1'b0; cyc = 0;
        while (!done && cyc < 3000) begin
            if (pend) begin
                check("t4_rise", 32'(seq_err), 32'd1);
                pend = 1'b0;
            end
            if (r_trigger && r_ready) begin
                if (xk == 2) begin
                    check("t4_before", 32'(seq_err), 32'd0);
                    pend = 1'b1;
                end
                xk++;
            end
            tick;
            cyc++;
        end
        check("t4_done", 32'(done), 32'd1);
        verify_burst("t4", cb, wb);
        check("t4_sticky", 32'(seq_err), 32'd1);
        tick;
        fill(BL, 16'h0010, 16'h0001);
        pulse_start;
        wait_done("t4b", 2000, cyc);
        check("t4b_sticky", 32'(seq_err), 32'd1);
        tick;
        do_reset;
        check("t4_rst_clr", 32'(seq_err), 32'd0);
        fill(BL, 16'h0000, 16'h0001);
        pulse_start;
        wait_done("t4c", 2000, cyc);
        check("t4c_seq", 32'(seq_err), 32'd0);
        tick;

        // Reset during word 100, byte 1
        fill(BL, 16'h0100, 16'h0001);
        cb = cap_n; dc0 = done_cnt;
        pulse_start;
        cyc = 0;
        while (!((cap_n - cb) == 201 && o_valid) && cyc < 2000) begin
            tick;
            cyc++;
        end
        check("t5_reach", 32'(cap_n - cb), 32'd201);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", 32'({busy, r_trigger, o_valid, o_last, done, seq_err, o_data}), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
        check("t5_partial", 32'(cap_n - cb), 32'd201);
        fill(BL, 16'h0000, 16'h0001);
        wb = rd_ptr; cb = cap_n;
        pulse_start;
        wait_done("t5", 2000, cyc);
        verify_burst("t5", cb, wb);
        check("t5_seq", 32'(seq_err), 32'd0);
        tick;

        // start while busy, then back-to-back bursts
        fill(BL, 16'h0200, 16'h0001);
        words[rd_ptr + BL] = 16'h0300;
        for (int k = 1; k < BL; k++) words[rd_ptr + BL + k] = 16'h0300 + W'(k);
        wb = rd_ptr; cb = cap_n; dc0 = done_cnt;
        pulse_start;
        cyc = 0;
        while ((cap_n - cb) < 20 && cyc < 2000) begin
            tick;
            cyc++;
        end
        pulse_start;
        wait_done("t6a", 2000, cyc);
        verify_burst("t6a", cb, wb);
        tick;
        check("t6_done_fell", 32'(done), 32'd0);
        pulse_start;
        check("t6_busy_b", 32'(busy), 32'd1);
        wait_done("t6b", 2000, cyc);
        verify_burst("t6b", cb + 2 * BL, wb + BL);
        tick;
        check("t6_done_pulses", 32'(done_cnt - dc0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_byte_drain.md
Name: fifo_byte_drain

Overview:
- Downstream consumer of the bank FIFO read port.
- On a start pulse it drains a fixed-length burst of W-bit words using the FIFO's trigger/ready handshake.
- Each word is serialized MSB-byte-first onto an 8-bit valid/ready byte stream, for the SPI/host readout path.
- It also checks that the word stream is non-decreasing and flags violations, the same check the bank FIFO bring-up tests make.

Parameters:
- W, 16, FIFO word width; must be a multiple of 8 and at least 16.
- BURST_LEN, 256, number of words drained per start.
- CNT_W, 9, counter width; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  in  1  Sole clock; all state is on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Single-cycle burst request. Ignored while busy.
- busy  out  1  High from the cycle after an accepted start through the DONE cycle.
- r_trigger  out  1  FIFO read request.
- r_data  in  W  FIFO read data. Valid when r_ready && r_trigger.
- r_ready  in  1  FIFO has data.
- o_data  out  8  Output byte.
- o_valid  out  1  o_data valid.
- o_ready  in  1  Sink accepts the byte.
- o_last  out  1  Marks the final byte of the burst. Qualified by o_valid.
- done  out  1  One-cycle pulse after the final byte is accepted.
- seq_err  out  1  Sticky error flag: a word arrived that is smaller than the previous word.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; lastWord 0; haveLast 0. All outputs are registered.
- Handshakes:
  - A FIFO word transfers on any clk edge where r_ready && r_trigger.
  - A byte transfers on any clk edge where o_valid && o_ready.
- State IDLE:
  - r_trigger=0, o_valid=0.
  - start=1 moves to FETCH with wordCnt=0 and busy=1 on the next edge.
- State FETCH:
  - r_trigger=1. r_trigger asserts the cycle after start is sampled.
  - On transfer: shift register <= r_data, byteIdx=0, r_trigger=0 on the next edge, then go to SHIFT.
  - Sequence check on the same edge: if haveLast && r_data < lastWord, set seq_err=1.
  - Also on the same edge: lastWord <= r_data, haveLast <= 1.
  - seq_err stays set until rst.
- State SHIFT:
  - o_valid=1. o_data is byte (W/8-1-byteIdx) of the shift register, i.e. MSB first.
  - o_data and o_last are held stable while o_valid && !o_ready.
  - On byte transfer, when byteIdx is not the last byte: byteIdx++.
  - On byte transfer of the last byte of the word:
    - If wordCnt == BURST_LEN-1, go to DONE.
    - Otherwise wordCnt++ and go to FETCH.
  - o_last=1 only while presenting the last byte of word BURST_LEN-1.
- State DONE:
  - done=1 and o_valid=0 for exactly one cycle.
  - busy deasserts on the following edge; return to IDLE.
- Throughput: one bubble cycle per word (SHIFT→FETCH→SHIFT). With r_ready and o_ready held high, a burst takes BURST_LEN*(W/8+1)+2 cycles from start to done.
- Boundary conditions:
  - FIFO empty (r_ready=0) in FETCH: hold r_trigger=1 indefinitely; no timeout; o_valid stays 0.
  - Sink stall: no FIFO read occurs while in SHIFT, so backpressure reaches the FIFO.
  - start while busy, including in the DONE cycle: ignored.
  - start in the first IDLE cycle after DONE: accepted.
  - Equal consecutive words: not an error, because the check is strictly less-than.
  - lastWord carries across bursts, so the first word of a burst is checked against the last word of the previous burst.
  - The first word after reset is never flagged.
  - rst asserted mid-burst, at any state: immediate return to reset values. The partial burst is abandoned; no done pulse and no o_last.
- Widths: wordCnt and byteIdx are unsigned. Comparisons are unsigned at W bits.

Test Plan:
- Basic burst: reset, then start with r_ready=1, o_ready=1, FIFO supplying 0x0000..0x00FF. Required: 512 bytes 00,00,00,01,...,00,FF; o_last only on the 512th byte; done 770 cycles after start; seq_err=0.
- Backpressure: o_ready toggling 1,0,0 repeating on word 0xABCD. Required: o_data stays 0xAB while stalled, then 0xCD; r_trigger=0 throughout SHIFT; byte order is preserved.
- Empty FIFO: r_ready=0 for 50 cycles after start, then 1. Required: r_trigger=1 for all 50 cycles, o_valid=0, then the burst completes normally.
- Sequence error: words 0x0005, 0x0005, 0x0004. Required: seq_err rises on the edge the 0x0004 transfer occurs and stays 1 through the next burst. A fresh reset then burst 0x0000.. leaves seq_err=0.
- Reset mid-burst: assert rst during word 100, byte 1. Required: all outputs are 0 immediately. A following start drains 256 fresh words with done and o_last correct, and the first word is not flagged.
- start while busy plus back-to-back bursts: pulse start at word 10 (ignored). Then pulse start in the cycle after done falls. Required: exactly 2 done pulses total, and the second burst's first byte comes from the next FIFO word.
